serial_add_ctrl: RTL and testbench

Multi-cycle controller that performs a WIDTH-bit add or subtract by sequencing one SLICE-bit full_adder instance over WIDTH/SLICE cycles, least-significant slice first, with the carry held in a register between slices. It uses valid/ready handshakes on both input and output. It serves area-constrained datapaths, such as the multi-cycle core variant and address-generation helpers, that share one narrow adder.

---
 rtl/serial_add_ctrl_pkg.sv | 28 ++
 rtl/serial_add_ctrl_fa.sv | 19 +
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_pkg
// Shared types and helpers for the serial add/subtract controller.
//   sadd_state_t : controller FSM states (IDLE, RUN, DONE)
//   nslice()     : number of adder slices needed for a WIDTH-bit operand
//   idx_bits()   : width of the slice index counter (never below 1 bit)
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SLICE = 8;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // A 1-bit counter is still needed when only two slices exist.
  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_IDX_W = idx_bits(nslice(DEFAULT_WIDTH, DEFAULT_SLICE));

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// full_adder
// Combinational WIDTH-bit ripple adder used as the shared slice datapath.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin (low WIDTH bits)
//   cout : carry out of the top bit
module full_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Multi-cycle WIDTH-bit add/subtract built from one SLICE-bit full_adder,
// processing one slice per cycle, least-significant slice first.
//   clk, reset_n         : clock and asynchronous active-low reset
//   in_valid / in_ready  : operation request handshake (ready only in IDLE)
//   op_a, op_b, sub, cin_i : operands; sub=1 computes A-B and ignores cin_i
//   out_valid / out_ready: result handshake
//   result, cout, overflow : sum/difference, MSB carry-out, signed overflow
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             cin_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDX_W  = idx_bits(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (((WIDTH % SLICE) != 0) || (NSLICE < 2)) begin : g_bad_params
    $error("serial_add_ctrl: WIDTH must be a multiple of SLICE with at least two slices");
  end

  sadd_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [SLICE-1:0] fa_a, fa_b, fa_sum;
  logic             fa_cout;

  // b_q already holds the inverted operand for subtraction.
  assign fa_a = a_q[idx_q*SLICE +: SLICE];
  assign fa_b = b_q[idx_q*SLICE +: SLICE];

  full_adder #(.WIDTH(SLICE)) u_slice_adder (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state logic: accept in IDLE, one slice per cycle in RUN, hold in DONE.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub | cin_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q*SLICE +: SLICE] = fa_sum;
        carry_d = fa_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d      = fa_cout;
          // Same-sign operands producing an opposite-sign sum.
          ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (fa_sum[SLICE-1] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Directed self-checking bench for serial_add_ctrl with default parameters.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        cin_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(32), .SLICE(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin_i     (cin_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one operation and returns just after the accepting edge.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic c);
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    sub      = s;
    cin_i    = c;
    in_valid = 1'b1;
    checkValue({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid (bounded), then checks latency and the result.
  task automatic checkOutput(input string tag, input logic [31:0] exp_res,
                             input logic exp_cout, input logic exp_ovf);
    int lat;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    checkValue({tag, "_latency"}, lat, 32'd4);
    checkValue({tag, "_result"}, result, exp_res);
    checkValue({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    checkValue({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  // Completes the output handshake and checks the return to IDLE.
  task automatic popResult(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkValue({tag, "_pop_valid"}, {31'd0, out_valid}, 32'd0);
    checkValue({tag, "_pop_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    cin_i     = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkValue("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkValue("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkValue("rst_result", result, 32'd0);
    checkValue("rst_cout", {31'd0, cout}, 32'd0);
    checkValue("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Carry across the first slice boundary
    applyStimulus("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("add_ff_1", 32'h0000_0100, 1'b0, 1'b0);
    popResult("add_ff_1");

    // Full ripple through every slice
    applyStimulus("add_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("add_ripple", 32'h0000_0000, 1'b1, 1'b0);
    popResult("add_ripple");

    applyStimulus("add_cin", 32'd1, 32'd1, 1'b0, 1'b1);
    checkOutput("add_cin", 32'd3, 1'b0, 1'b0);
    popResult("add_cin");

    // Signed overflow on add
    applyStimulus("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    checkOutput("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    popResult("add_ovf");

    // Subtraction, including borrow, ignored cin_i and signed overflow
    applyStimulus("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b0);
    checkOutput("sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0);
    popResult("sub_5_7");

    applyStimulus("sub_7_5", 32'd7, 32'd5, 1'b1, 1'b0);
    checkOutput("sub_7_5", 32'd2, 1'b1, 1'b0);
    popResult("sub_7_5");

    applyStimulus("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 1'b1);
    checkOutput("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
    popResult("sub_ovf");

    // Backpressure: outputs hold and new requests are refused
    applyStimulus("bp", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    checkOutput("bp", 32'h2345_6789, 1'b0, 1'b0);
    @(negedge clk);
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h0BAD_F00D;
    sub      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkValue("bp_hold_result", result, 32'h2345_6789);
      checkValue("bp_hold_cout", {31'd0, cout}, 32'd0);
      checkValue("bp_hold_ovf", {31'd0, overflow}, 32'd0);
      checkValue("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      checkValue("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    popResult("bp");

    applyStimulus("bp_next", 32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0);
    checkOutput("bp_next", 32'h0000_00FF, 1'b1, 1'b0);
    popResult("bp_next");

    // Reset during RUN after two slices have been processed
    applyStimulus("mid_rst", 32'h0101_0101, 32'h0101_0101, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkValue("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    checkValue("mid_rst_result", result, 32'd0);
    checkValue("mid_rst_cout", {31'd0, cout}, 32'd0);
    checkValue("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkValue("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    checkValue("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);

    applyStimulus("post_rst", 32'd3, 32'd4, 1'b0, 1'b0);
    checkOutput("post_rst", 32'd7, 1'b0, 1'b0);
    popResult("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
